// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences core reset, runs the core,
// counts cycles/instructions and ends the run on a PC self-loop halt or a cycle watchdog.
module mips_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 10,
  parameter int HALT_REPEAT = 4,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int SC_W = $clog2(HALT_REPEAT + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RST, RUN, DONE, TIMEOUT} state_t;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [SC_W-1:0]  same_cnt;
  logic [PC_W-1:0]  last_pc;

  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] ins_nxt;
  logic [SC_W-1:0]  same_nxt;
  logic             halt_hit;
  logic             wd_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // same_cnt==0 marks "no sample yet this run", so a stale last_pc never extends a streak
  always_comb begin
    cyc_nxt  = sat_inc(cycle_cnt);
    ins_nxt  = pc_valid ? sat_inc(instr_cnt) : instr_cnt;
    same_nxt = same_cnt;
    if (pc_valid) begin
      if ((same_cnt != '0) && (pc == last_pc)) same_nxt = same_cnt + SC_W'(1);
      else                                     same_nxt = SC_W'(1);
    end
    halt_hit = pc_valid && (same_nxt == SC_W'(HALT_REPEAT));
    wd_hit   = (cyc_nxt == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      rst_cnt    <= '0;
      same_cnt   <= '0;
      last_pc    <= '0;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state      <= RST;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
            rst_cnt    <= '0;
            same_cnt   <= '0;
          end
        end
        RST: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        RUN: begin
          cycle_cnt <= cyc_nxt;
          instr_cnt <= ins_nxt;
          if (pc_valid) begin
            same_cnt <= same_nxt;
            last_pc  <= pc;
          end
          // halt wins over the watchdog when both land on the same cycle
          if (halt_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b1;
            running    <= 1'b0;
          end else if (wd_hit) begin
            state      <= TIMEOUT;
            timeout    <= 1'b1;
            core_reset <= 1'b1;
            running    <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: stimulus queues cycle-stamped expected outputs,
// a negedge monitor pops and compares them against the selected DUT instance.
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;

  logic        cr_a, run_a, dn_a, to_a;
  logic [31:0] cc_a, ic_a;
  logic        cr_b, run_b, dn_b, to_b;
  logic [3:0]  cc_b, ic_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int    cyc;
    bit    sel;
    string name;
    logic  cr, run, dn, to;
    int    cc, ic;
  } exp_t;

  exp_t exp_q[$];

  mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYCLES(10), .HALT_REPEAT(4), .MAX_CYCLES(50)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .pc(pc), .pc_valid(pc_valid),
    .core_reset(cr_a), .running(run_a), .done(dn_a), .timeout(to_a),
    .cycle_cnt(cc_a), .instr_cnt(ic_a));

  mips_run_ctrl #(.PC_W(32), .CNT_W(4), .RST_CYCLES(10), .HALT_REPEAT(4), .MAX_CYCLES(15)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .pc(pc), .pc_valid(pc_valid),
    .core_reset(cr_b), .running(run_b), .done(dn_b), .timeout(to_b),
    .cycle_cnt(cc_b), .instr_cnt(ic_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every expectation stamped with the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic a_cr, a_run, a_dn, a_to;
      int   a_cc, a_ic;
      e = exp_q.pop_front();
      if (e.sel) begin
        a_cr = cr_b; a_run = run_b; a_dn = dn_b; a_to = to_b;
        a_cc = int'(cc_b); a_ic = int'(ic_b);
      end else begin
        a_cr = cr_a; a_run = run_a; a_dn = dn_a; a_to = to_a;
        a_cc = int'(cc_a); a_ic = int'(ic_a);
      end
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
      end else if (a_cr !== e.cr || a_run !== e.run || a_dn !== e.dn || a_to !== e.to ||
                   a_cc != e.cc || a_ic != e.ic) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got cr=%b run=%b done=%b to=%b cc=%0d ic=%0d, want cr=%b run=%b done=%b to=%b cc=%0d ic=%0d",
                 e.name, cyc, a_cr, a_run, a_dn, a_to, a_cc, a_ic,
                 e.cr, e.run, e.dn, e.to, e.cc, e.ic);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit sel, input logic cr, input logic run,
                            input logic dn, input logic to, input int cc, input int ic);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.name = name;
    e.cr = cr; e.run = run; e.dn = dn; e.to = to; e.cc = cc; e.ic = ic;
    exp_q.push_back(e);
  endtask

  // one-cycle start pulse, 10 RST cycles with counters/flags cleared, then first RUN cycle
  task automatic launch(input bit sel, input string name);
    pc_valid = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    expect_out({name, "_rst_entry"}, sel, 1, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      expect_out({name, "_rst_hold"}, sel, 1, 0, 0, 0, 0, 0);
    end
    tick();
    expect_out({name, "_run_entry"}, sel, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] seq2 [7];
    logic [31:0] seq4 [5];
    seq2 = '{32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h300c, 32'h300c, 32'h300c};
    seq4 = '{32'h3010, 32'h3010, 32'h3010, 32'h3014, 32'h3010};

    // reset state
    tick(); tick();
    expect_out("reset_a", 0, 1, 0, 0, 0, 0, 0);
    expect_out("reset_b", 1, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("idle_a", 0, 1, 0, 0, 0, 0, 0);

    // core reset sequencing, then cycle_cnt 1,2,3...; start held in RUN is ignored
    launch(0, "t1");
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_out("t1_count", 0, 0, 1, 0, 0, k, 0);
    end
    start_a = 1'b1;
    for (int k = 4; k <= 20; k++) begin
      tick();
      expect_out("t5_start_ignored", 0, 0, 1, 0, 0, k, 0);
    end
    // reset mid-RUN dominates a held start
    reset = 1'b1;
    tick();
    expect_out("t5_reset_midrun", 0, 1, 0, 0, 0, 0, 0);
    reset = 1'b0; start_a = 1'b0;
    tick();
    expect_out("t5_idle_after", 0, 1, 0, 0, 0, 0, 0);

    // self-loop halt after 4 repeats of 0x300c
    launch(0, "t2");
    pc_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc = seq2[i];
      tick();
      if (i < 6) expect_out("t2_run", 0, 0, 1, 0, 0, i + 1, i + 1);
      else       expect_out("t2_done", 0, 1, 0, 1, 0, 7, 7);
    end
    pc_valid = 1'b0;
    tick();
    expect_out("t2_frozen", 0, 1, 0, 1, 0, 7, 7);

    // restart from DONE clears flags/counters; idle gaps do not break the halt streak
    launch(0, "t6a");
    pc_valid = 1'b1; pc = 32'h3010;
    tick();
    expect_out("t4a_first", 0, 0, 1, 0, 0, 1, 1);
    pc_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      expect_out("t4a_gap", 0, 0, 1, 0, 0, k, 1);
    end
    pc_valid = 1'b1;
    tick(); expect_out("t4a_rep2", 0, 0, 1, 0, 0, 5, 2);
    tick(); expect_out("t4a_rep3", 0, 0, 1, 0, 0, 6, 3);
    tick(); expect_out("t4a_done", 0, 1, 0, 1, 0, 7, 4);

    // broken streak reloads to 1; stale last_pc from the prior run must not count
    launch(0, "t4b");
    pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = seq4[i];
      tick();
      expect_out("t4b_no_halt", 0, 0, 1, 0, 0, i + 1, i + 1);
    end

    // watchdog with strictly increasing pc: timeout at cycle 50
    for (int k = 6; k <= 50; k++) begin
      pc = 32'h4000 + 32'(k * 4);
      tick();
      if (k < 50) expect_out("t3_run", 0, 0, 1, 0, 0, k, k);
      else        expect_out("t3_timeout", 0, 1, 0, 0, 1, 50, 50);
    end
    tick();
    expect_out("t3_to_frozen", 0, 1, 0, 0, 1, 50, 50);

    // 4th repeat lands on cycle 50: halt wins
    launch(0, "t3b");
    pc_valid = 1'b0;
    for (int k = 1; k <= 46; k++) tick();
    expect_out("t3b_wait", 0, 0, 1, 0, 0, 46, 0);
    pc_valid = 1'b1; pc = 32'h5000;
    for (int k = 47; k <= 50; k++) begin
      tick();
      if (k < 50) expect_out("t3b_run", 0, 0, 1, 0, 0, k, k - 46);
      else        expect_out("t3b_done_wins", 0, 1, 0, 1, 0, 50, 4);
    end

    // 4-bit counters, budget 15: timeout at 15, no wrap over a 20-cycle attempt
    launch(1, "t6b");
    pc_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      pc = 32'h6000 + 32'(k * 4);
      tick();
      if (k < 15)       expect_out("t6b_run", 1, 0, 1, 0, 0, k, k);
      else if (k == 15) expect_out("t6b_timeout", 1, 1, 0, 0, 1, 15, 15);
      else              expect_out("t6b_no_wrap", 1, 1, 0, 0, 1, 15, 15);
    end
    pc_valid = 1'b0;

    tick(); tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
